booth_mul_ctrl: RTL
===================

BOOTH_MUL_CTRL -- requirements
Module: booth_mul_ctrl

Interface
REQ-001 Parameters: none; operand width fixed at 32 bits, product width fixed at 64 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 a  input  32  multiplicand, two's-complement; sampled on the edge that accepts start.
REQ-006 b  input  32  multiplier, two's-complement; sampled on the edge that accepts start.
REQ-007 busy  output  1  high while state is RUN.
REQ-008 done  output  1  one-cycle pulse; high while state is DONE.
REQ-009 hi  output  32  product bits [63:32], registered.
REQ-010 lo  output  32  product bits [31:0], registered.

Function
REQ-011 Block SHALL compute the signed 64-bit product a*b by radix-2 Booth recoding, one iteration per clock.
REQ-012 All accumulation SHALL go through exactly one adder_64b instance; no other adder or "+"/"-" on 64-bit data is permitted.
REQ-013 Registers: ACC[63:0], MC[63:0] (sign-extended multiplicand), Q[31:0] (multiplier), QM1 (1 bit), CNT[5:0], state.
REQ-014 FSM states: IDLE, RUN, DONE; encoding is free.
REQ-015 IDLE: if start=1 at an edge -> RUN; ACC<=0, MC<={{32{a[31]}},a}, Q<=b, QM1<=0, CNT<=0; else remain in IDLE.
REQ-016 RUN, per edge, on {Q[0],QM1}: 01 -> ACC<=ACC+MC (adder y=MC, cin=0); 10 -> ACC<=ACC-MC (adder y=~MC, cin=1); 00/11 -> ACC unchanged.
REQ-017 RUN, every edge: MC<=MC<<1; QM1<=Q[0]; Q<={Q[31],Q[31:1]}; CNT<=CNT+1.
REQ-018 RUN with CNT=31 at an edge: final iteration is performed, {hi,lo} <= the new ACC value, state -> DONE.
REQ-019 DONE: done=1 for exactly one cycle; next edge -> IDLE unconditionally.
REQ-020 Latency: start accepted at edge E0; 32 iterations at E1..E32; done high during the cycle after E32; earliest next start acceptance is at E34.
REQ-021 start while in RUN or DONE SHALL be ignored; it is neither queued nor allowed to corrupt a, b, or the in-flight operation.
REQ-022 hi/lo SHALL hold their last product from the DONE cycle until the next result is written; they SHALL NOT change during RUN.
REQ-023 Arithmetic is modulo 2^64; adder cout is ignored; the result is exact for all 2^64 operand pairs, including a=b=0x80000000.
REQ-024 busy and done SHALL never be high simultaneously; busy=0 in IDLE and DONE.

Reset
REQ-025 rst=1 SHALL immediately (without a clock) force state=IDLE, busy=0, done=0, hi=0, lo=0, ACC=0, MC=0, Q=0, QM1=0, CNT=0.
REQ-026 rst asserted mid-RUN SHALL abort the operation, produce no done pulse, and leave hi/lo=0.
REQ-027 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-028 a=3, b=4, start 1 cycle -> busy for 32 cycles, done pulse at E33 cycle, hi=0x00000000, lo=0x0000000C.
REQ-029 a=0xFFFFFFFB (-5), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFDD; a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0, lo=1.
REQ-030 a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0; a=0x7FFFFFFF, b=0x80000000 -> hi=0xC0000000, lo=0x80000000.
REQ-031 Start 2*3; pulse start with a=9, b=9 at iteration 10 -> ignored; result hi=0, lo=6; done pulses exactly once.
REQ-032 Start 3*4; assert rst at iteration 15 -> busy=0 and done=0 immediately, hi/lo=0, no done pulse; then start 5*6 -> lo=30.
REQ-033 Back-to-back: start held high continuously -> operations accepted at E0, E34, E68, ...; the done pulses are 34 cycles apart.

Source files
------------

// File: rtl/booth_mul_ctrl.sv
// Signed 32x32 -> 64-bit multiplier, radix-2 Booth, one iteration per clock.
// Latency: start accepted at E0, 32 iterations E1..E32, done pulse in the cycle after E32.
// Backpressure: none; start is only sampled in IDLE and ignored while RUN or DONE.

// Plain 64-bit ripple/carry adder; the only adder on the accumulator datapath.
module adder_64b (
  input  logic [63:0] x,
  input  logic [63:0] y,
  input  logic        cin,
  output logic [63:0] s,
  output logic        cout
);

  logic [64:0] sum;

  // Full 65-bit sum so the carry-out is available to callers that want it.
  assign sum  = {1'b0, x} + {1'b0, y} + {64'd0, cin};
  assign s    = sum[63:0];
  assign cout = sum[64];

endmodule

module booth_mul_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] mc_q, mc_d;
  logic [31:0] q_q, q_d;
  logic        qm1_q, qm1_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [1:0]  booth_sel;
  logic        do_sub;
  logic [63:0] add_y;
  logic [63:0] add_s;
  logic [63:0] acc_next;
  logic        unused_cout;

  // Booth pair {Q0,QM1}: 01 adds MC, 10 subtracts MC (as ~MC + 1), 00/11 keep ACC.
  always_comb begin
    booth_sel = {q_q[0], qm1_q};
    do_sub    = (booth_sel == 2'b10);
    add_y     = do_sub ? ~mc_q : mc_q;
    acc_next  = (q_q[0] ^ qm1_q) ? add_s : acc_q;
  end

  // Carry-out is meaningless here: arithmetic wraps modulo 2^64.
  adder_64b u_adder (
    .x    (acc_q),
    .y    (add_y),
    .cin  (do_sub),
    .s    (add_s),
    .cout (unused_cout)
  );

  // Next-state and datapath updates for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mc_d    = mc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          acc_d   = 64'd0;
          mc_d    = {{32{a[31]}}, a};
          q_d     = b;
          qm1_d   = 1'b0;
          cnt_d   = 6'd0;
        end
      end
      ST_RUN: begin
        acc_d = acc_next;
        mc_d  = {mc_q[62:0], 1'b0};
        qm1_d = q_q[0];
        q_d   = {q_q[31], q_q[31:1]};
        cnt_d = cnt_q + 6'd1;
        // Last iteration: publish the freshly computed accumulator.
        if (cnt_q == 6'd31) begin
          state_d = ST_DONE;
          hi_d    = acc_next[63:32];
          lo_d    = acc_next[31:0];
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= 64'd0;
      mc_q    <= 64'd0;
      q_q     <= 32'd0;
      qm1_q   <= 1'b0;
      cnt_q   <= 6'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mc_q    <= mc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
